// File: rtl/debounce_sync_if.sv
// Signal bundle for debounce_sync: raw asynchronous input in, conditioned level and edge pulses out.
interface debounce_sync_if;
    logic din;
    logic dout;
    logic dout_n;
    logic rise;
    logic fall;

    modport master (
        output din,
        input  dout,
        input  dout_n,
        input  rise,
        input  fall
    );

    modport slave (
        input  din,
        output dout,
        output dout_n,
        output rise,
        output fall
    );
endinterface

// File: rtl/debounce_sync.sv
// Synchronises and debounces one async bit; outputs update SYNC_STAGES+STABLE_CYCLES edges after a held change.
// No backpressure: the level and rise/fall pulses are free-running registered outputs.
module debounce_sync #(
    parameter int SYNC_STAGES   = 2,
    parameter int STABLE_CYCLES = 1000,
    parameter int CNT_W         = 16
) (
    input  logic            clk,
    input  logic            rst,
    debounce_sync_if.slave  bus
);

    typedef enum logic [1:0] {
        ST_LOW     = 2'd0,
        ST_WAIT_HI = 2'd1,
        ST_HIGH    = 2'd2,
        ST_WAIT_LO = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

    generate
        if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_sync
            $error("debounce_sync: SYNC_STAGES must be 2..4");
        end
        if (STABLE_CYCLES < 1) begin : g_bad_stable
            $error("debounce_sync: STABLE_CYCLES must be at least 1");
        end
        if ((longint'(STABLE_CYCLES) - 64'sd1) >= (64'sd1 <<< CNT_W)) begin : g_bad_cnt_w
            $error("debounce_sync: CNT_W too narrow for STABLE_CYCLES-1");
        end
    endgenerate

    logic [SYNC_STAGES-1:0] sync;
    logic                   s_out;

    state_t                 state;
    state_t                 state_nxt;
    logic [CNT_W-1:0]       cnt;
    logic [CNT_W-1:0]       cnt_nxt;

    logic                   dout_q;
    logic                   dout_n_q;
    logic                   rise_q;
    logic                   fall_q;
    logic                   dout_nxt;
    logic                   rise_nxt;
    logic                   fall_nxt;

    logic                   differ;
    logic                   at_last;

    // Only the last stage is read; sync[0] may be metastable.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync <= '0;
        end else begin
            sync <= {sync[SYNC_STAGES-2:0], bus.din};
        end
    end

    assign s_out   = sync[SYNC_STAGES-1];
    assign differ  = s_out ^ dout_q;
    assign at_last = (cnt == CNT_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_LOW;
            cnt      <= '0;
            dout_q   <= 1'b0;
            dout_n_q <= 1'b1;
            rise_q   <= 1'b0;
            fall_q   <= 1'b0;
        end else begin
            state    <= state_nxt;
            cnt      <= cnt_nxt;
            dout_q   <= dout_nxt;
            dout_n_q <= ~dout_nxt;
            rise_q   <= rise_nxt;
            fall_q   <= fall_nxt;
        end
    end

    // The first differing edge already counts, so a settled state with
    // CNT_LAST == 0 commits straight away without visiting the WAIT state.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            ST_LOW, ST_WAIT_HI: begin
                if (!differ) begin
                    state_nxt = ST_LOW;
                    cnt_nxt   = '0;
                end else if (at_last) begin
                    state_nxt = ST_HIGH;
                    cnt_nxt   = '0;
                end else begin
                    state_nxt = ST_WAIT_HI;
                    cnt_nxt   = cnt + CNT_W'(1);
                end
            end
            ST_HIGH, ST_WAIT_LO: begin
                if (!differ) begin
                    state_nxt = ST_HIGH;
                    cnt_nxt   = '0;
                end else if (at_last) begin
                    state_nxt = ST_LOW;
                    cnt_nxt   = '0;
                end else begin
                    state_nxt = ST_WAIT_LO;
                    cnt_nxt   = cnt + CNT_W'(1);
                end
            end
            default: begin
                state_nxt = ST_LOW;
                cnt_nxt   = '0;
            end
        endcase
    end

    always_comb begin
        dout_nxt = dout_q;
        rise_nxt = 1'b0;
        fall_nxt = 1'b0;
        if ((state == ST_LOW || state == ST_WAIT_HI) && state_nxt == ST_HIGH) begin
            dout_nxt = 1'b1;
            rise_nxt = 1'b1;
        end else if ((state == ST_HIGH || state == ST_WAIT_LO) && state_nxt == ST_LOW) begin
            dout_nxt = 1'b0;
            fall_nxt = 1'b1;
        end
    end

    assign bus.dout   = dout_q;
    assign bus.dout_n = dout_n_q;
    assign bus.rise   = rise_q;
    assign bus.fall   = fall_q;

    a_pulse_excl: assert property (@(posedge clk) disable iff (rst) !(rise_q && fall_q));
    a_dout_compl: assert property (@(posedge clk) disable iff (rst) dout_n_q == ~dout_q);
    a_cnt_range:  assert property (@(posedge clk) disable iff (rst) cnt <= CNT_LAST);

endmodule

// File: tb/tb_debounce_sync.sv
// Bench for debounce_sync with SYNC_STAGES=2, STABLE_CYCLES=4: expectations queued per edge, checked after it.
module tb_debounce_sync;

    localparam logic [3:0] E_LO   = 4'b0100;  // {dout, dout_n, rise, fall}
    localparam logic [3:0] E_HI   = 4'b1000;
    localparam logic [3:0] E_RISE = 4'b1010;
    localparam logic [3:0] E_FALL = 4'b0101;

    logic clk;
    logic rst;
    int   total;
    int   bad;

    logic [3:0] exp_q[$];
    string      tag_q[$];

    debounce_sync_if bus();

    debounce_sync #(
        .SYNC_STAGES  (2),
        .STABLE_CYCLES(4),
        .CNT_W        (3)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Drive one edge's worth of stimulus and queue the outputs expected right after that edge.
    task automatic drive(input logic d, input logic r, input logic [3:0] e, input string tag);
        @(negedge clk);
        bus.din = d;
        rst     = r;
        exp_q.push_back(e);
        tag_q.push_back(tag);
    endtask

    initial begin : monitor
        logic [3:0] obs;
        logic [3:0] e;
        string      t;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e   = exp_q.pop_front();
                t   = tag_q.pop_front();
                obs = {bus.dout, bus.dout_n, bus.rise, bus.fall};
                chk(t, 32'(obs), 32'(e));
            end
        end
    end

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1, "bench timed out");
    end

    initial begin : stim
        total   = 0;
        bad     = 0;
        rst     = 1'b1;
        bus.din = 1'b0;

        // Reset held with din high, then released.
        drive(1'b1, 1'b1, E_LO, "rst_hold");
        drive(1'b1, 1'b1, E_LO, "rst_hold");
        drive(1'b1, 1'b0, E_LO, "rst_release");
        for (int i = 0; i < 6; i++) drive(1'b0, 1'b0, E_LO, "idle");

        // Clean rise.
        for (int e = 1; e <= 10; e++)
            drive(1'b1, 1'b0, (e < 6) ? E_LO : (e == 6) ? E_RISE : E_HI, "clean_rise");

        // Clean fall.
        for (int e = 1; e <= 10; e++)
            drive(1'b0, 1'b0, (e < 6) ? E_HI : (e == 6) ? E_FALL : E_LO, "clean_fall");

        // Bounce: 1,1,0 then 1 held.
        drive(1'b1, 1'b0, E_LO, "bounce_pre");
        drive(1'b1, 1'b0, E_LO, "bounce_pre");
        drive(1'b0, 1'b0, E_LO, "bounce_pre");
        for (int e = 1; e <= 10; e++)
            drive(1'b1, 1'b0, (e < 6) ? E_LO : (e == 6) ? E_RISE : E_HI, "bounce_rise");
        for (int e = 1; e <= 8; e++)
            drive(1'b0, 1'b0, (e < 6) ? E_HI : (e == 6) ? E_FALL : E_LO, "bounce_fall");

        // Short pulse: three samples high is one short of STABLE_CYCLES.
        for (int e = 1; e <= 3; e++) drive(1'b1, 1'b0, E_LO, "short_hi");
        for (int e = 1; e <= 8; e++) drive(1'b0, 1'b0, E_LO, "short_lo");

        // Reset pulse mid-count restarts the whole pipeline.
        for (int e = 1; e <= 12; e++)
            drive(1'b1, (e == 4), (e < 10) ? E_LO : (e == 10) ? E_RISE : E_HI, "rst_mid");
        for (int e = 1; e <= 8; e++)
            drive(1'b0, 1'b0, (e < 6) ? E_HI : (e == 6) ? E_FALL : E_LO, "rst_mid_fall");

        // Reset on the terminal-count edge suppresses the rise.
        for (int e = 1; e <= 14; e++)
            drive(1'b1, (e == 6), (e < 12) ? E_LO : (e == 12) ? E_RISE : E_HI, "rst_terminal");

        // Reset while HIGH forces outputs low even with din high.
        drive(1'b1, 1'b1, E_LO, "rst_in_high");
        drive(1'b1, 1'b0, E_LO, "rst_in_high_rel");

        repeat (3) @(posedge clk);
        #2;
        chk("drain", 32'(exp_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
